// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: single-beat bus, lane steering, load extension.
// Optional trap on misaligned accesses: define DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wd_M,
  input  logic [2:0]  load_sel_M,
  input  logic [2:0]  store_sel_M,
  output logic        stall_M,
  output logic [31:0] rdata_M,
  output logic        misalign_M,
  output logic        timeout_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_lsel;
  logic [7:0]  r_wd;

  logic        w_go;
  logic        w_we;
  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_go = mem_read_M | mem_write_M;
  // write wins when both strobes are set
  assign w_we = mem_write_M;

  assign stall_M = ((r_state == S_IDLE) & w_go) |
                   (r_state == S_REQ);

  // access size from funct3; unknown load codes act as byte (never trap)
  always_comb begin
    w_size = SZ_B;
    if (w_we) begin
      case (store_sel_M)
        3'b000:  w_size = SZ_B;
        3'b001:  w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end else begin
      case (load_sel_M)
        3'b001, 3'b101: w_size = SZ_H;
        3'b010:         w_size = SZ_W;
        default:        w_size = SZ_B;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = ((w_size == SZ_H) & addr_M[0]) |
                  ((w_size == SZ_W) & (addr_M[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
  assign misalign_M = 1'b0;
`endif

  // aligned lane offset, byte enables and replicated store data
  always_comb begin
    w_off   = addr_M[1:0];
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    case (w_size)
      SZ_H:    w_off = {addr_M[1], 1'b0};
      SZ_W:    w_off = 2'b00;
      default: w_off = addr_M[1:0];
    endcase
    if (w_we) begin
      case (w_size)
        SZ_B: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{wd_M[7:0]}};
        end
        SZ_H: begin
          w_be    = 4'b0011 << w_off;
          w_wdata = {2{wd_M[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wd_M;
        end
      endcase
    end
  end

  // pick the addressed byte/half from the returned word and extend it
  always_comb begin
    w_byte = bus_rdata[7:0];
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_ext  = 32'h0;
    case (r_off)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    case (r_lsel)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = bus_rdata;
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = 32'h0;
    endcase
  end

  // transaction FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_off     <= 2'b00;
      r_lsel    <= 3'b000;
      r_wd      <= 8'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'h0;
      rdata_M   <= 32'h0;
      timeout_M <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_M <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (w_trap) begin
              r_state <= S_DONE;
              rdata_M <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
              misalign_M <= 1'b1;
`endif
            end else begin
              r_state   <= S_REQ;
              r_off     <= w_off;
              r_lsel    <= load_sel_M;
              r_wd      <= 8'h0;
              bus_req   <= 1'b1;
              bus_we    <= w_we;
              bus_addr  <= {addr_M[31:2], 2'b00};
              bus_wdata <= w_wdata;
              bus_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_state <= S_DONE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata_M <= w_ext;
            end
          end else if (r_wd == 8'd254) begin
            r_state   <= S_DONE;
            bus_req   <= 1'b0;
            timeout_M <= 1'b1;
            rdata_M   <= 32'h0;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          timeout_M <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
          misalign_M <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed stores, loads, timeout,
// reset abort and misaligned word load.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_M;
  logic        mem_write_M;
  logic [31:0] addr_M;
  logic [31:0] wd_M;
  logic [2:0]  load_sel_M;
  logic [2:0]  store_sel_M;
  logic        stall_M;
  logic [31:0] rdata_M;
  logic        misalign_M;
  logic        timeout_M;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  dmem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read_M (mem_read_M),
    .mem_write_M(mem_write_M),
    .addr_M     (addr_M),
    .wd_M       (wd_M),
    .load_sel_M (load_sel_M),
    .store_sel_M(store_sel_M),
    .stall_M    (stall_M),
    .rdata_M    (rdata_M),
    .misalign_M (misalign_M),
    .timeout_M  (timeout_M),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we,
                        input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int dly, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic [31:0] e_rd);
    exp_t e;
    int   stalls;
    e.we    = we;
    e.addr  = e_addr;
    e.be    = e_be;
    e.wdata = e_wd;
    e.rdata = we ? last_rd : e_rd;
    sb.push_back(e);
    @(negedge clk);
    mem_write_M = we;
    mem_read_M  = ~we;
    addr_M      = addr;
    wd_M        = wd;
    load_sel_M  = sel;
    store_sel_M = sel;
    bus_ack     = 1'b0;
    stalls = 0;
    #1;
    if (stall_M) stalls++;
    @(posedge clk);
    #1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (stall_M) stalls++;
      chk({tag, ".wait_req"}, {31'h0, bus_req}, 32'h1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    if (stall_M) stalls++;
    bus_ack   = 1'b1;
    bus_rdata = word;
    e = sb.pop_front();
    chk({tag, ".req"}, {31'h0, bus_req}, 32'h1);
    chk({tag, ".we"}, {31'h0, bus_we}, {31'h0, e.we});
    chk({tag, ".addr"}, bus_addr, e.addr);
    chk({tag, ".be"}, {28'h0, bus_be}, {28'h0, e.be});
    if (e.we) chk({tag, ".wdata"}, bus_wdata, e.wdata);
    @(posedge clk);
    #1;
    bus_ack     = 1'b0;
    mem_read_M  = 1'b0;
    mem_write_M = 1'b0;
    @(negedge clk);
    chk({tag, ".done_stall"}, {31'h0, stall_M}, 32'h0);
    chk({tag, ".done_req"}, {31'h0, bus_req}, 32'h0);
    chk({tag, ".rdata"}, rdata_M, e.rdata);
    chk({tag, ".stall_cyc"}, stalls, dly + 2);
    last_rd = e.rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    int reqs;
    rst_n       = 1'b0;
    mem_read_M  = 1'b0;
    mem_write_M = 1'b0;
    addr_M      = 32'h0;
    wd_M        = 32'h0;
    load_sel_M  = 3'b0;
    store_sel_M = 3'b0;
    bus_ack     = 1'b0;
    bus_rdata   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req", {31'h0, bus_req}, 32'h0);
    chk("rst.addr", bus_addr, 32'h0);
    chk("rst.be", {28'h0, bus_be}, 32'h0);
    chk("rst.rdata", rdata_M, 32'h0);
    chk("rst.flags", {30'h0, timeout_M, misalign_M}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    access("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
           32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    access("sb", 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0,
           32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
    access("sh", 1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 3,
           32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0);
    access("lb", 0, 3'b000, 32'h203, 32'h0, 32'h8081F0F0, 0,
           32'h200, 4'b1111, 32'h0, 32'hFFFFFF80);
    access("lbu", 0, 3'b100, 32'h203, 32'h0, 32'h8081F0F0, 1,
           32'h200, 4'b1111, 32'h0, 32'h00000080);
    access("lh", 0, 3'b001, 32'h200, 32'h0, 32'h8081F0F0, 0,
           32'h200, 4'b1111, 32'h0, 32'hFFFFF0F0);
    access("lhu", 0, 3'b101, 32'h202, 32'h0, 32'h8081F0F0, 0,
           32'h200, 4'b1111, 32'h0, 32'h00008081);
    access("lundef", 0, 3'b011, 32'h200, 32'h0, 32'h8081F0F0, 0,
           32'h200, 4'b1111, 32'h0, 32'h0);
    access("lw", 0, 3'b010, 32'h204, 32'h0, 32'h12345678, 2,
           32'h204, 4'b1111, 32'h0, 32'h12345678);
    access("sb_hold", 1, 3'b000, 32'h101, 32'h0000003C, 32'h0, 0,
           32'h100, 4'b0010, 32'h3C3C3C3C, 32'h0);

    // watchdog abort
    @(negedge clk);
    mem_read_M = 1'b1;
    addr_M     = 32'h300;
    load_sel_M = 3'b010;
    @(posedge clk);
    #1;
    mem_read_M = 1'b0;
    reqs = 0;
    while (stall_M && reqs < 300) begin
      reqs++;
      @(posedge clk);
      #1;
    end
    chk("to.req_cycles", reqs, 255);
    chk("to.pulse", {31'h0, timeout_M}, 32'h1);
    chk("to.rdata", rdata_M, 32'h0);
    chk("to.req_low", {31'h0, bus_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("to.pulse_end", {31'h0, timeout_M}, 32'h0);
    chk("to.idle_stall", {31'h0, stall_M}, 32'h0);
    @(posedge clk);
    #1;
    chk("to.no_reissue", {31'h0, bus_req}, 32'h0);
    last_rd = 32'h0;

    // reset during REQ, then a late ack
    access("lw_pre", 0, 3'b010, 32'h400, 32'h0, 32'h00001111, 0,
           32'h400, 4'b1111, 32'h0, 32'h00001111);
    @(negedge clk);
    mem_read_M = 1'b1;
    addr_M     = 32'h400;
    load_sel_M = 3'b010;
    @(posedge clk);
    #1;
    chk("rr.req_up", {31'h0, bus_req}, 32'h1);
    mem_read_M = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rr.req_drop", {31'h0, bus_req}, 32'h0);
    chk("rr.rdata_rst", rdata_M, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rr.stall", {31'h0, stall_M}, 32'h0);
    chk("rr.req", {31'h0, bus_req}, 32'h0);
    chk("rr.rdata", rdata_M, 32'h0);
    chk("rr.timeout", {31'h0, timeout_M}, 32'h0);
    last_rd = 32'h0;

    // misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_read_M = 1'b1;
    addr_M     = 32'h102;
    load_sel_M = 3'b010;
    #1;
    chk("mis.stall", {31'h0, stall_M}, 32'h1);
    chk("mis.req0", {31'h0, bus_req}, 32'h0);
    @(posedge clk);
    #1;
    mem_read_M = 1'b0;
    chk("mis.flag", {31'h0, misalign_M}, 32'h1);
    chk("mis.req1", {31'h0, bus_req}, 32'h0);
    chk("mis.rdata", rdata_M, 32'h0);
    chk("mis.done_stall", {31'h0, stall_M}, 32'h0);
    @(posedge clk);
    #1;
    chk("mis.flag_end", {31'h0, misalign_M}, 32'h0);
    chk("mis.req2", {31'h0, bus_req}, 32'h0);
`else
    access("lw_mis", 0, 3'b010, 32'h102, 32'h0, 32'h55AA55AA, 0,
           32'h100, 4'b1111, 32'h0, 32'h55AA55AA);
    chk("mis.tied0", {31'h0, misalign_M}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
